// File: rtl/sdram_ahb_arbiter_pkg.sv
// Shared types and AHB-Lite constants for the SDRAM arbiter.
//  arb_state_t : transfer sequencer states
//  HTRANS_*, HSIZE_WORD, HBURST_SINGLE, HPROT_DEFAULT : fixed bus encodings
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} arb_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
endpackage

// File: rtl/sdram_ahb_arbiter_if.sv
// AHB-Lite link between the arbiter (master) and the SDRAM controller (slave).
//  master : drives address/control/write data and HREADY, receives HREADYOUT/HRDATA/HRESP
//  slave  : the mirror view
interface sdram_ahb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [DW-1:0] HRDATA;
  logic          HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/sdram_ahb_arbiter_rr.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NREQ.
//  req     : pending requests
//  ptr     : highest-priority index
//  gnt     : one-hot winner
//  gnt_idx : winner index
//  any     : at least one request pending
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);
  int w_idx;

  // Scan from the farthest offset down so the nearest request (offset 0) wins last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (req[w_idx]) begin
        gnt        = '0;
        gnt[w_idx] = 1'b1;
        gnt_idx    = IW'(w_idx);
        any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sdram_ahb_arbiter.sv
// Shares one AHB-Lite SDRAM slave between NREQ request/response clients.
// One single-word transfer at a time: grant (IDLE) -> address phase (ADDR) -> data phase (DATA).
//  HCLK, HRESET           : clock, synchronous active-high reset
//  req_valid/write/addr/wdata : per-client request, held until req_ready
//  req_ready              : one-hot grant pulse (combinational)
//  rsp_valid/rsp_rdata/rsp_err : one-hot completion pulse with shared read data / error
//  ahb                    : AHB-Lite master port
module sdram_ahb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  sdram_ahb_arbiter_if.master ahb
);
  arb_state_t    r_state, w_next;
  logic [IW-1:0] r_ptr, r_gidx;
  logic          r_write, r_hsel;
  logic [1:0]    r_htrans;
  logic [2:0]    r_hsize;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_hwdata, r_rdata;
  logic [NREQ-1:0] r_rsp_valid;
  logic          r_err;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx),
    .any     (w_any)
  );

  assign w_addr  = req_addr[w_gidx*AW +: AW];
  assign w_wdata = req_wdata[w_gidx*DW +: DW];

  // Grant only while idle and out of reset; the capture happens on the same edge.
  assign req_ready = (r_state == IDLE && !HRESET) ? w_gnt : '0;

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ADDR;
      ADDR:    w_next = DATA;
      DATA:    if (ahb.HREADYOUT) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_hsel      <= 1'b0;
      r_htrans    <= HTRANS_IDLE;
      r_hsize     <= 3'b000;
      r_hwdata    <= '0;
      r_rsp_valid <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_hsize     <= HSIZE_WORD;
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_gidx   <= w_gidx;
          r_write  <= req_write[w_gidx];
          r_addr   <= w_addr & ~AW'(3);
          r_wdata  <= w_wdata;
          r_ptr    <= (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
          r_hsel   <= 1'b1;
          r_htrans <= HTRANS_NONSEQ;
        end
        ADDR: begin
          r_hsel   <= 1'b0;
          r_htrans <= HTRANS_IDLE;
          r_hwdata <= r_wdata;
        end
        DATA: if (ahb.HREADYOUT) begin
          r_rsp_valid[r_gidx] <= 1'b1;
          r_rdata             <= r_write ? '0 : ahb.HRDATA;
          r_err               <= ahb.HRESP;
        end
        default: ;
      endcase
    end
  end

  assign ahb.HSEL      = r_hsel;
  assign ahb.HADDR     = r_addr;
  assign ahb.HTRANS    = r_htrans;
  assign ahb.HWRITE    = r_write;
  assign ahb.HSIZE     = r_hsize;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HPROT     = HPROT_DEFAULT;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWDATA    = r_hwdata;
  // Sole slave on the bus, so its HREADYOUT is the bus HREADY.
  assign ahb.HREADY    = ahb.HREADYOUT;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
endmodule

// File: tb/tb_sdram_ahb_arbiter.sv
// Directed bench for sdram_ahb_arbiter with a behavioural AHB-Lite memory slave
// (configurable wait states and two-cycle ERROR response).
module tb_sdram_ahb_arbiter;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [1:0]  req_valid = '0, req_write = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int cfg_wait = 0;
  bit cfg_err = 1'b0;

  sdram_ahb_arbiter_if #(.AW(32), .DW(32)) bus ();

  sdram_ahb_arbiter #(.NREQ(2), .AW(32), .DW(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ahb(bus)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic [31:0] mem [0:63];
  bit          mem_ok = 1'b0;
  bit          ph_act = 1'b0, ph_write = 1'b0, ph_err = 1'b0, err_first = 1'b0;
  logic [31:0] ph_addr = '0;
  int          wait_left = 0;

  assign bus.HREADYOUT = !ph_act || (wait_left == 0 && !err_first);
  assign bus.HRESP     = ph_act && ph_err && (wait_left == 0);
  assign bus.HRDATA    = (ph_act && !ph_write) ? mem[ph_addr[7:2]] : 32'h0;

  always @(posedge HCLK) begin
    if (!mem_ok) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem_ok <= 1'b1;
    end
    if (HRESET) ph_act <= 1'b0;
    else begin
      if (ph_act) begin
        if (bus.HREADYOUT) begin
          if (ph_write && !ph_err) mem[ph_addr[7:2]] <= bus.HWDATA;
          ph_act <= 1'b0;
        end else if (wait_left > 0) wait_left <= wait_left - 1;
        else err_first <= 1'b0;
      end
      if (bus.HSEL && bus.HTRANS[1] && bus.HREADY) begin
        ph_act    <= 1'b1;
        ph_addr   <= bus.HADDR;
        ph_write  <= bus.HWRITE;
        wait_left <= cfg_wait;
        ph_err    <= cfg_err;
        err_first <= cfg_err;
      end
    end
  end

  // ---------------- client helpers ----------------
  task automatic set_req(input int c, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_write[c]         = w;
    req_addr[c*32 +: 32] = a;
    req_wdata[c*32 +: 32] = d;
  endtask

  // One transfer from client c; gcyc/rcyc are cycle stamps of grant and response.
  task automatic xfer(input int c, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int gcyc, output int rcyc,
                      output bit ok);
    ok = 1'b0; rd = '0; er = 1'b0; gcyc = -1; rcyc = -1;
    @(posedge HCLK); #1;
    set_req(c, w, a, d);
    req_valid[c] = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge HCLK);
      if (req_ready[c]) begin gcyc = cyc; break; end
    end
    @(posedge HCLK); #1;
    req_valid[c] = 1'b0;
    if (gcyc < 0) return;
    for (int t = 0; t < 60; t++) begin
      @(negedge HCLK);
      if (rsp_valid[c]) begin rcyc = cyc; rd = rsp_rdata; er = rsp_err; ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [79:0] bus_o;
    HRESET = 1'b1;
    set_req(1, 1'b0, 32'h0, 32'h0);
    req_valid = 2'b10;
    repeat (5) @(posedge HCLK);
    @(negedge HCLK);
    bus_o = {bus.HSEL, bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT,
             bus.HMASTLOCK, bus.HWDATA, bus.HREADY};
    n_checks++;
    if (bus_o !== {1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 3'b000, 4'b0011, 1'b0, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL reset_ahb: got %h expected %h", bus_o,
        {1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 3'b000, 4'b0011, 1'b0, 32'h0, 1'b1});
    end
    n_checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== 37'h0) begin
      n_fail++; $display("FAIL reset_client: got %h expected 0", {req_ready, rsp_valid, rsp_rdata, rsp_err});
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL first_grant: got %b expected 10", req_ready); end
    @(posedge HCLK); #1;
    req_valid = 2'b00;
    @(negedge HCLK);
    n_checks++;
    if ({bus.HSEL, bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE} !== {1'b1, 2'b10, 32'h0, 1'b0, 3'b010}) begin
      n_fail++; $display("FAIL addr_phase: got %h expected %h",
        {bus.HSEL, bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE}, {1'b1, 2'b10, 32'h0, 1'b0, 3'b010});
    end
    @(negedge HCLK);
    n_checks++;
    if ({bus.HSEL, bus.HTRANS, rsp_valid} !== 5'b0_00_00) begin
      n_fail++; $display("FAIL data_phase: got %b expected 00000", {bus.HSEL, bus.HTRANS, rsp_valid});
    end
    @(negedge HCLK);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL first_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b0, 32'h0});
    end
    @(negedge HCLK);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rsp_pulse: got %b expected 00", rsp_valid); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int g, r; bit ok;
    xfer(0, 1'b1, 32'h10, 32'hAA5555AA, rd, er, g, r, ok);
    n_checks++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0} || r - g != 3) begin
      n_fail++; $display("FAIL write_10: got ok=%0d err=%0d rdata=%h lat=%0d expected ok=1 err=0 rdata=0 lat=3",
        ok, er, rd, r - g);
    end
    xfer(1, 1'b0, 32'h13, 32'h0, rd, er, g, r, ok);
    n_checks++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'hAA5555AA} || r - g != 3) begin
      n_fail++; $display("FAIL read_10: got ok=%0d err=%0d rdata=%h lat=%0d expected ok=1 err=0 rdata=aa5555aa lat=3",
        ok, er, rd, r - g);
    end
  endtask

  task automatic test_round_robin();
    int gl[6]; int gc[6]; logic [31:0] hl[6];
    int ng = 0, nh = 0, nr = 0, k0 = 0, k1 = 0;
    logic [1:0] gr; logic [31:0] a;
    @(posedge HCLK); #1;
    set_req(0, 1'b1, 32'h14, 32'hC0DE0014);
    set_req(1, 1'b1, 32'h18, 32'hC0DE0018);
    req_valid = 2'b11;
    for (int t = 0; t < 80 && nr < 6; t++) begin
      @(negedge HCLK);
      if (bus.HSEL && nh < 6) begin hl[nh] = bus.HADDR; nh++; end
      nr += int'(rsp_valid[0]) + int'(rsp_valid[1]);
      gr = req_ready;
      if (gr[0] && ng < 6) begin gl[ng] = 0; gc[ng] = cyc; ng++; end
      if (gr[1] && ng < 6) begin gl[ng] = 1; gc[ng] = cyc; ng++; end
      @(posedge HCLK); #1;
      if (gr[0]) begin
        k0++;
        a = 32'h14 + 32'(8 * k0);
        if (k0 < 3) set_req(0, 1'b1, a, 32'hC0DE0000 | a); else req_valid[0] = 1'b0;
      end
      if (gr[1]) begin
        k1++;
        a = 32'h18 + 32'(8 * k1);
        if (k1 < 3) set_req(1, 1'b1, a, 32'hC0DE0000 | a); else req_valid[1] = 1'b0;
      end
    end
    req_valid = 2'b00;
    n_checks++;
    if (nr != 6 || ng != 6 || nh != 6) begin
      n_fail++; $display("FAIL rr_count: got rsp=%0d gnt=%0d addr=%0d expected 6 each", nr, ng, nh);
    end else begin
      for (int k = 0; k < 6; k++) begin
        a = 32'h14 + 32'(4 * k);
        n_checks++;
        if (gl[k] != k % 2) begin n_fail++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, gl[k], k % 2); end
        n_checks++;
        if (hl[k] !== a) begin n_fail++; $display("FAIL rr_haddr%0d: got %h expected %h", k, hl[k], a); end
        n_checks++;
        if (mem[a[7:2]] !== (32'hC0DE0000 | a)) begin
          n_fail++; $display("FAIL rr_wdata%0d: got %h expected %h", k, mem[a[7:2]], 32'hC0DE0000 | a);
        end
        if (k > 0) begin
          n_checks++;
          if (gc[k] - gc[k-1] != 3) begin n_fail++; $display("FAIL rr_gap%0d: got %0d expected 3", k, gc[k] - gc[k-1]); end
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int st = 0; bit gnt = 1'b0;
    @(posedge HCLK); #1;
    cfg_wait = 7;
    set_req(0, 1'b1, 32'h30, 32'h5A5A1234);
    req_valid[0] = 1'b1;
    for (int t = 0; t < 20 && !gnt; t++) begin
      @(negedge HCLK);
      gnt = req_ready[0];
    end
    @(posedge HCLK); #1;
    req_valid[0] = 1'b0;
    n_checks++;
    if (!gnt) begin n_fail++; $display("FAIL ws_grant: got none expected grant"); return; end
    @(negedge HCLK);
    for (int t = 0; t < 30; t++) begin
      @(negedge HCLK);
      if (bus.HREADYOUT) break;
      st++;
      n_checks++;
      if ({bus.HWDATA, bus.HTRANS, rsp_valid} !== {32'h5A5A1234, 2'b00, 2'b00}) begin
        n_fail++; $display("FAIL ws_stall%0d: got %h expected %h", st, {bus.HWDATA, bus.HTRANS, rsp_valid},
          {32'h5A5A1234, 2'b00, 2'b00});
      end
    end
    n_checks++;
    if (st != 7) begin n_fail++; $display("FAIL ws_len: got %0d expected 7", st); end
    @(negedge HCLK);
    n_checks++;
    if ({rsp_valid, rsp_err} !== 3'b010) begin n_fail++; $display("FAIL ws_rsp: got %b expected 010", {rsp_valid, rsp_err}); end
    @(negedge HCLK);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL ws_pulse: got %b expected 00", rsp_valid); end
    n_checks++;
    if (mem[12] !== 32'h5A5A1234) begin n_fail++; $display("FAIL ws_mem: got %h expected 5a5a1234", mem[12]); end
    cfg_wait = 0;
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int g, r; bit ok;
    cfg_err = 1'b1;
    xfer(1, 1'b0, 32'h20, 32'h0, rd, er, g, r, ok);
    cfg_err = 1'b0;
    n_checks++;
    if ({ok, er} !== 2'b11 || r - g != 4) begin
      n_fail++; $display("FAIL err_rsp: got ok=%0d err=%0d lat=%0d expected ok=1 err=1 lat=4", ok, er, r - g);
    end
    xfer(0, 1'b0, 32'h20, 32'h0, rd, er, g, r, ok);
    n_checks++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'hC0DE0020} || r - g != 3) begin
      n_fail++; $display("FAIL err_next: got ok=%0d err=%0d rdata=%h lat=%0d expected ok=1 err=0 rdata=c0de0020 lat=3",
        ok, er, rd, r - g);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int g, r; bit ok; bit gnt = 1'b0; int bad = 0;
    @(posedge HCLK); #1;
    cfg_wait = 20;
    set_req(0, 1'b1, 32'h1C, 32'h12345678);
    req_valid[0] = 1'b1;
    for (int t = 0; t < 20 && !gnt; t++) begin
      @(negedge HCLK);
      gnt = req_ready[0];
    end
    @(posedge HCLK); #1;
    req_valid[0] = 1'b0;
    repeat (4) @(negedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    cfg_wait = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge HCLK);
      if (rsp_valid !== 2'b00 || bus.HSEL !== 1'b0 || bus.HTRANS !== 2'b00) bad++;
    end
    n_checks++;
    if (!gnt || bad != 0) begin n_fail++; $display("FAIL abort: got grant=%0d bad_cycles=%0d expected grant=1 bad_cycles=0", gnt, bad); end
    n_checks++;
    if (mem[7] !== 32'hC0DE001C) begin n_fail++; $display("FAIL abort_mem: got %h expected c0de001c", mem[7]); end
    xfer(0, 1'b1, 32'h1C, 32'hEEEE7777, rd, er, g, r, ok);
    xfer(1, 1'b0, 32'h1C, 32'h0, rd, er, g, r, ok);
    n_checks++;
    if ({ok, er, rd} !== {1'b1, 1'b0, 32'hEEEE7777}) begin
      n_fail++; $display("FAIL post_reset_read: got ok=%0d err=%0d rdata=%h expected ok=1 err=0 rdata=eeee7777", ok, er, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_wait_states();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
